led_matrix_scan_ctrl: RTL

Scan controller for the 8x8 LED matrix driven on the top-level `row`/`col` pins. It time-multiplexes the eight matrix rows and holds two 8x8 frame buffers, front and back. The game FSM writes the back buffer, and a request/acknowledge swap makes the back buffer the front only at a frame boundary, so the display never tears. It also provides row guard blanking against ghosting, a global blank input, and a frame tick that game logic can use as a timebase.

---
 rtl/led_matrix_scan_if.sv | 25 ++
 rtl/led_matrix_scan_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/led_matrix_scan_if.sv
// Write bus and swap handshake between the game logic and the LED matrix scan controller.
// The master side is the game FSM; the slave side is the scan controller.
interface led_matrix_scan_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       swap_req;
  logic       swap_ack;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    output swap_req,
    input  swap_ack
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  swap_req,
    output swap_ack
  );
endinterface

// File: rtl/led_matrix_scan_ctrl.sv
// 8x8 LED matrix row scanner with double-buffered frames, tear-free swap at frame wrap,
// per-row guard blanking, global blank and a frame tick.
module led_matrix_scan_ctrl #(
  parameter int unsigned DIV   = 2500,
  parameter int unsigned GUARD = 2
) (
  input  logic                 system_clk,
  input  logic                 rst_n,
  led_matrix_scan_if.slave     bus,
  input  logic                 blank,
  output logic                 frame_tick,
  output logic [7:0]           row,
  output logic [7:0]           col
);

  localparam logic [15:0] CNT_LAST  = 16'(DIV - 1);
  localparam logic [15:0] GUARD_CNT = 16'(GUARD);

  logic [15:0] cnt_r;
  logic [2:0]  ridx_r;
  logic        sel_r;
  logic        pend_r;
  logic [7:0]  buf0_r [8];
  logic [7:0]  buf1_r [8];
  logic        swap_ack_r;
  logic        frame_tick_r;
  logic [7:0]  row_r;
  logic [7:0]  col_r;

  logic        wrap_s;
  logic        boundary_s;
  logic        swap_s;
  logic        dark_s;
  logic [7:0]  front_row_s;

  // Scan position decode, swap decision and front-buffer row read
  always_comb begin
    wrap_s      = (cnt_r == CNT_LAST);
    boundary_s  = wrap_s && (ridx_r == 3'd7);
    swap_s      = boundary_s && (pend_r || bus.swap_req);
    dark_s      = blank || (cnt_r < GUARD_CNT);
    if (sel_r) begin
      front_row_s = buf1_r[ridx_r];
    end else begin
      front_row_s = buf0_r[ridx_r];
    end
  end

  // Dwell counter and row index
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      cnt_r  <= 16'd0;
      ridx_r <= 3'd0;
    end else if (wrap_s) begin
      cnt_r  <= 16'd0;
      ridx_r <= ridx_r + 3'd1;
    end else begin
      cnt_r  <= cnt_r + 16'd1;
    end
  end

  // Swap handshake; a request still high during the ack cycle is not re-latched
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      sel_r        <= 1'b0;
      pend_r       <= 1'b0;
      swap_ack_r   <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      if (swap_s) begin
        sel_r  <= ~sel_r;
        pend_r <= 1'b0;
      end else if (bus.swap_req && !swap_ack_r) begin
        pend_r <= 1'b1;
      end else begin
        pend_r <= pend_r;
      end
      swap_ack_r   <= swap_s;
      frame_tick_r <= boundary_s;
    end
  end

  // Back-buffer writes use the pre-swap select, so a same-cycle write lands in the new front
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        buf0_r[i] <= 8'h00;
        buf1_r[i] <= 8'h00;
      end
    end else if (bus.wr_en) begin
      if (sel_r) begin
        buf0_r[bus.wr_addr] <= bus.wr_data;
      end else begin
        buf1_r[bus.wr_addr] <= bus.wr_data;
      end
    end
  end

  // Registered row/column drive
  always_ff @(posedge system_clk) begin
    if (!rst_n) begin
      row_r <= 8'h00;
      col_r <= 8'hFF;
    end else if (dark_s) begin
      row_r <= 8'h00;
      col_r <= 8'hFF;
    end else begin
      row_r <= 8'h01 << ridx_r;
      col_r <= ~front_row_s;
    end
  end

  assign bus.swap_ack = swap_ack_r;
  assign frame_tick   = frame_tick_r;
  assign row          = row_r;
  assign col          = col_r;

endmodule
